// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped, write-back, write-allocate data cache controller.
// One 32-bit word per line; a miss writes back a dirty victim, then fills the line.
// Ports:
//   clk, rstn                     clock, async active-low reset
//   cache_req_*                   core request (held stable until cache_resp_valid)
//   cache_resp_valid/data         one-cycle completion pulse with load data / store echo
//   cache_stall                   pipeline freeze
//   mem_req_*                     memory request (held until mem_resp_valid)
//   mem_resp_valid/data           memory completion pulse with fill data
module dcache_ctrl #(
    parameter int unsigned INDEX_W = 6,
    parameter int unsigned TAG_W   = 30 - INDEX_W
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        cache_req_valid,
    input  logic        cache_req_wen,
    input  logic [31:0] cache_req_addr,
    input  logic [31:0] cache_req_data,
    output logic        cache_resp_valid,
    output logic [31:0] cache_resp_data,
    output logic        cache_stall,
    output logic        mem_req_valid,
    output logic        mem_req_wen,
    output logic [31:0] mem_req_addr,
    output logic [31:0] mem_req_data,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_data
);

    localparam int unsigned LINES = 1 << INDEX_W;

    typedef enum logic [1:0] {IDLE, COMPARE, WRBACK, ALLOC} state_t;

    state_t state_q, state_d;

    logic               req_wen_q;
    logic [INDEX_W-1:0] req_idx_q;
    logic [TAG_W-1:0]   req_tag_q;
    logic [31:0]        req_data_q;

    logic [LINES-1:0]   valid_q;
    logic [LINES-1:0]   dirty_q;
    logic [TAG_W-1:0]   tag_q  [LINES];
    logic [31:0]        data_q [LINES];

    logic hit_c;
    logic victim_dirty_c;
    logic unused_addr_bits;

    // Byte offset within the word carries no information for a word cache.
    assign unused_addr_bits = ^cache_req_addr[1:0];

    assign hit_c          = valid_q[req_idx_q] && (tag_q[req_idx_q] == req_tag_q);
    assign victim_dirty_c = valid_q[req_idx_q] && dirty_q[req_idx_q];

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cache_req_valid) state_d = COMPARE;
            COMPARE: begin
                if (hit_c)               state_d = IDLE;
                else if (victim_dirty_c) state_d = WRBACK;
                else                     state_d = ALLOC;
            end
            WRBACK:  if (mem_resp_valid) state_d = ALLOC;
            ALLOC:   if (mem_resp_valid) state_d = COMPARE;
            default: state_d = IDLE;
        endcase
    end

    // Output decode from state, request registers and line storage.
    always_comb begin
        cache_resp_valid = 1'b0;
        cache_resp_data  = '0;
        mem_req_valid    = 1'b0;
        mem_req_wen      = 1'b0;
        mem_req_addr     = '0;
        mem_req_data     = '0;
        case (state_q)
            COMPARE: begin
                if (hit_c) begin
                    cache_resp_valid = 1'b1;
                    cache_resp_data  = req_wen_q ? req_data_q : data_q[req_idx_q];
                end
            end
            WRBACK: begin
                mem_req_valid = 1'b1;
                mem_req_wen   = 1'b1;
                mem_req_addr  = {tag_q[req_idx_q], req_idx_q, 2'b00};
                mem_req_data  = data_q[req_idx_q];
            end
            ALLOC: begin
                mem_req_valid = 1'b1;
                mem_req_addr  = {req_tag_q, req_idx_q, 2'b00};
            end
            default: ;
        endcase
        // Held core request must not keep the pipeline frozen while in reset.
        cache_stall = rstn && (((state_q != IDLE) && !cache_resp_valid) ||
                               ((state_q == IDLE) && cache_req_valid));
    end

    // Request registers, captured only on acceptance in IDLE.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            req_wen_q  <= 1'b0;
            req_idx_q  <= '0;
            req_tag_q  <= '0;
            req_data_q <= '0;
        end else if ((state_q == IDLE) && cache_req_valid) begin
            req_wen_q  <= cache_req_wen;
            req_idx_q  <= cache_req_addr[INDEX_W+1:2];
            req_tag_q  <= cache_req_addr[31:INDEX_W+2];
            req_data_q <= cache_req_data;
        end
    end

    // Valid/dirty bits: cleared by reset, which invalidates the whole cache.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            case (state_q)
                COMPARE: if (hit_c && req_wen_q) dirty_q[req_idx_q] <= 1'b1;
                WRBACK:  if (mem_resp_valid)     dirty_q[req_idx_q] <= 1'b0;
                ALLOC: begin
                    if (mem_resp_valid) begin
                        valid_q[req_idx_q] <= 1'b1;
                        dirty_q[req_idx_q] <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Tag and data arrays: no reset, qualified by valid bits.
    always_ff @(posedge clk) begin
        if ((state_q == COMPARE) && hit_c && req_wen_q) begin
            data_q[req_idx_q] <= req_data_q;
        end else if ((state_q == ALLOC) && mem_resp_valid) begin
            tag_q[req_idx_q]  <= req_tag_q;
            data_q[req_idx_q] <= mem_resp_data;
        end
    end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl: directed scenarios followed by random
// loads/stores over a small conflicting address pool. A flat architectural
// memory predicts load data; a tag directory predicts hit/miss and memory traffic.
module tb_dcache_ctrl;

    logic        clk = 1'b0;
    logic        rstn;
    logic        cache_req_valid;
    logic        cache_req_wen;
    logic [31:0] cache_req_addr;
    logic [31:0] cache_req_data;
    logic        cache_resp_valid;
    logic [31:0] cache_resp_data;
    logic        cache_stall;
    logic        mem_req_valid;
    logic        mem_req_wen;
    logic [31:0] mem_req_addr;
    logic [31:0] mem_req_data;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;

    dcache_ctrl #(.INDEX_W(6)) dut (
        .clk(clk), .rstn(rstn),
        .cache_req_valid(cache_req_valid), .cache_req_wen(cache_req_wen),
        .cache_req_addr(cache_req_addr), .cache_req_data(cache_req_data),
        .cache_resp_valid(cache_resp_valid), .cache_resp_data(cache_resp_data),
        .cache_stall(cache_stall),
        .mem_req_valid(mem_req_valid), .mem_req_wen(mem_req_wen),
        .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        wen;
        logic [31:0] addr;
        logic [31:0] data;
    } mreq_t;

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_q[$];
    mreq_t       exp_mem_q[$];

    logic [31:0] bmem [int unsigned];   // backing memory seen by the memory model
    logic [31:0] arch [int unsigned];   // architectural view the core must observe

    logic        m_valid [64];
    logic        m_dirty [64];
    logic [23:0] m_tag   [64];

    int          force_lat = -1;
    logic        mem_active = 1'b0;
    int          mem_cnt = 0;

    function automatic logic [31:0] dflt(input int unsigned k);
        return (k * 32'h9E37_79B1) ^ 32'h0000_1357;
    endfunction

    function automatic logic [31:0] rd_bmem(input int unsigned k);
        return bmem.exists(k) ? bmem[k] : dflt(k);
    endfunction

    function automatic logic [31:0] rd_arch(input int unsigned k);
        return arch.exists(k) ? arch[k] : dflt(k);
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Response monitor: pops the scoreboard whenever the DUT completes a request.
    always @(negedge clk) begin
        logic [31:0] e;
        if (!rstn) begin
            chk("resp_in_reset", 32'(cache_resp_valid), 32'd0);
        end else if (cache_resp_valid) begin
            if (exp_q.size() == 0) begin
                chk("resp_unexpected", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("resp_data", cache_resp_data, e);
            end
        end
    end

    // Memory model: random (or forced) latency, checks each request it completes.
    always @(negedge clk) begin
        mreq_t m;
        mem_resp_valid = 1'b0;
        mem_resp_data  = $urandom();
        if (!rstn) begin
            mem_active = 1'b0;
            exp_mem_q.delete();
        end else if (mem_req_valid) begin
            if (!mem_active) begin
                mem_active = 1'b1;
                mem_cnt = (force_lat >= 0) ? force_lat : int'($urandom_range(0, 5));
            end
            if (mem_cnt == 0) begin
                if (exp_mem_q.size() == 0) begin
                    chk("mem_unexpected", mem_req_addr, 32'hFFFF_FFFF);
                end else begin
                    m = exp_mem_q.pop_front();
                    chk("mem_wen", 32'(mem_req_wen), 32'(m.wen));
                    chk("mem_addr", mem_req_addr, m.addr);
                    if (m.wen) chk("mem_wdata", mem_req_data, m.data);
                end
                if (mem_req_wen) bmem[32'(mem_req_addr[31:2])] = mem_req_data;
                else             mem_resp_data = rd_bmem(32'(mem_req_addr[31:2]));
                mem_resp_valid = 1'b1;
                mem_active = 1'b0;
            end else begin
                mem_cnt--;
            end
        end
    end

    task automatic finish_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 64; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
            m_tag[i]   = '0;
        end
        arch = bmem;
    endtask

    // Issue one request; called and returns at posedge+1.
    task automatic do_req(input logic wen, input logic [31:0] addr, input logic [31:0] data);
        int unsigned idx;
        int unsigned k;
        logic [23:0] tag;
        logic        hit;
        logic        dmiss;
        int          n;
        int          lat;
        mreq_t       m;
        logic [31:0] e;
        idx = 32'(addr[7:2]);
        tag = addr[31:8];
        k   = 32'(addr[31:2]);
        hit   = m_valid[idx] && (m_tag[idx] == tag);
        dmiss = !hit && m_valid[idx] && m_dirty[idx];
        if (dmiss) begin
            m.wen  = 1'b1;
            m.addr = {m_tag[idx], 6'(idx), 2'b00};
            m.data = rd_arch(32'({m_tag[idx], 6'(idx)}));
            exp_mem_q.push_back(m);
        end
        if (!hit) begin
            m.wen  = 1'b0;
            m.addr = {addr[31:2], 2'b00};
            m.data = '0;
            exp_mem_q.push_back(m);
            m_valid[idx] = 1'b1;
            m_tag[idx]   = tag;
            m_dirty[idx] = 1'b0;
        end
        if (wen) begin
            m_dirty[idx] = 1'b1;
            arch[k] = data;
            e = data;
        end else begin
            e = rd_arch(k);
        end
        exp_q.push_back(e);

        cache_req_valid = 1'b1;
        cache_req_wen   = wen;
        cache_req_addr  = addr;
        cache_req_data  = data;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (cache_resp_valid) chk("stall_at_resp", 32'(cache_stall), 32'd0);
            else                  chk("stall_busy", 32'(cache_stall), 32'd1);
        end while (!cache_resp_valid && n < 100);
        if (!cache_resp_valid) begin
            $display("FAIL req_timeout: no response for addr %h after %0d cycles", addr, n);
            bad++;
            $display("test done: total=%0d bad=%0d", total, bad);
            $fatal(1, "request timeout");
        end
        lat = n - 1;
        if (hit)        chk("hit_latency", 32'(lat), 32'd1);
        else if (dmiss) chk("dirty_miss_min_lat", 32'(lat >= 4), 32'd1);
        else            chk("clean_miss_min_lat", 32'(lat >= 3), 32'd1);
        @(posedge clk);
        #1;
        cache_req_valid = 1'b0;
        cache_req_wen   = 1'($urandom());
        cache_req_data  = $urandom();
    endtask

    initial begin
        int n;
        rstn = 1'b0;
        cache_req_valid = 1'b0;
        cache_req_wen   = 1'b0;
        cache_req_addr  = '0;
        cache_req_data  = '0;
        bmem[32'h10 >> 2]  = 32'hDEAD_BEEF;
        bmem[32'h110 >> 2] = 32'hCAFE_0001;
        model_reset();
        #1;
        chk("rst_resp_valid", 32'(cache_resp_valid), 32'd0);
        chk("rst_resp_data", cache_resp_data, 32'd0);
        chk("rst_stall", 32'(cache_stall), 32'd0);
        chk("rst_mem_valid", 32'(mem_req_valid), 32'd0);
        chk("rst_mem_addr", mem_req_addr, 32'd0);
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        @(posedge clk);
        #1;

        // Directed scenarios.
        force_lat = 2;  do_req(1'b0, 32'h10, 32'h0);
        force_lat = -1; do_req(1'b0, 32'h10, 32'h0);
        do_req(1'b1, 32'h10, 32'h1234_5678);
        do_req(1'b0, 32'h10, 32'h0);
        force_lat = 1;  do_req(1'b0, 32'h110, 32'h0);
        force_lat = 0;  do_req(1'b1, 32'h20, 32'hA5A5_A5A5);
        do_req(1'b0, 32'h20, 32'h0);
        force_lat = 5;  do_req(1'b1, 32'h30, 32'h0F0F_1234);
        do_req(1'b0, 32'h30, 32'h0);

        // Reset while the fill for 0x210 is outstanding.
        force_lat = 30;
        cache_req_valid = 1'b1;
        cache_req_wen   = 1'b0;
        cache_req_addr  = 32'h210;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(mem_req_valid && !mem_req_wen) && n < 20);
        chk("alloc_reached", 32'(mem_req_valid && !mem_req_wen), 32'd1);
        chk("alloc_addr", mem_req_addr, 32'h210);
        @(posedge clk);
        #1 rstn = 1'b0;
        #1;
        chk("midmiss_rst_mem_valid", 32'(mem_req_valid), 32'd0);
        chk("midmiss_rst_stall", 32'(cache_stall), 32'd0);
        chk("midmiss_rst_resp", 32'(cache_resp_valid), 32'd0);
        cache_req_valid = 1'b0;
        repeat (3) @(negedge clk);
        model_reset();
        @(posedge clk);
        #1 rstn = 1'b1;
        force_lat = -1;
        @(posedge clk);
        #1;
        do_req(1'b0, 32'h110, 32'h0);

        // Random traffic over 4 tags x 4 indices.
        for (int i = 0; i < 200; i++) begin
            logic [31:0] a;
            a = ({30'($urandom_range(0, 3)), 8'h00}) | (32'($urandom_range(0, 3)) << 2)
                | 32'($urandom_range(0, 3));
            do_req(1'($urandom()), a, $urandom());
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                chk("idle_stall", 32'(cache_stall), 32'd0);
                @(posedge clk);
                #1;
            end
        end

        repeat (4) @(posedge clk);
        chk("resp_queue_drained", 32'(exp_q.size()), 32'd0);
        chk("mem_queue_drained", 32'(exp_mem_q.size()), 32'd0);
        finish_run();
    end

endmodule

// File: doc/dcache_ctrl.md
# dcache_ctrl

Direct-mapped, write-back, write-allocate data cache controller that responds to the core's cache requests (`cache_req_valid` / `cache_req_wen`, produced by the pipeline's MEM-stage control from the SW/LW opcodes). It answers from a local one-word-per-line array on a hit. On a miss it drives a valid/response handshake to main memory, evicting a dirty victim first. It sits between the MEM stage and the memory model, and stalls the pipeline while busy.

## Interface
- `INDEX_W`, 6: index width; the cache has 2^INDEX_W lines of one 32-bit word.
- `TAG_W`, 30-INDEX_W: tag width, covering addr[31:INDEX_W+2].
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rstn`  in  1  reset, asynchronous, active-low.
- `cache_req_valid`  in  1  core request present; held with stable fields until `cache_resp_valid`.
- `cache_req_wen`  in  1  1 = store (SW), 0 = load (LW).
- `cache_req_addr`  in  32  byte address; [1:0] ignored.
- `cache_req_data`  in  32  store data.
- `cache_resp_valid`  out  1  one-cycle pulse: request complete.
- `cache_resp_data`  out  32  load data; store data echoed for stores; valid only with `cache_resp_valid`.
- `cache_stall`  out  1  freeze pipeline.
- `mem_req_valid`  out  1  memory request; held until `mem_resp_valid`.
- `mem_req_wen`  out  1  1 = write-back, 0 = fill read.
- `mem_req_addr`  out  32  word-aligned memory address.
- `mem_req_data`  out  32  write-back data.
- `mem_resp_valid`  in  1  memory completion pulse.
- `mem_resp_data`  in  32  fill data, sampled with `mem_resp_valid`.

## Operation
- Address split: index = addr[INDEX_W+1:2], tag = addr[31:INDEX_W+2].
- Per-line storage: valid bit, dirty bit, tag, 32-bit data.
- FSM states: IDLE, COMPARE, WRBACK, ALLOC.
- IDLE: if `cache_req_valid`=1, latch wen/addr/data into request registers, then go to COMPARE.
- COMPARE, hit (valid && tag match):
  - Load: `cache_resp_data` = line data.
  - Store: line data <= req data, dirty <= 1; `cache_resp_data` = req data.
  - Pulse `cache_resp_valid`, go to IDLE.
- COMPARE, miss: go to WRBACK if victim valid && dirty, else go to ALLOC.
- WRBACK:
  - Drive `mem_req_valid`=1, `mem_req_wen`=1, `mem_req_addr`={victim tag, index, 2'b00}, `mem_req_data`=victim data.
  - On `mem_resp_valid`: clear dirty, go to ALLOC.
- ALLOC:
  - Drive `mem_req_valid`=1, `mem_req_wen`=0, `mem_req_addr`={req tag, index, 2'b00}.
  - On `mem_resp_valid`: line <= {valid=1, dirty=0, req tag, `mem_resp_data`}, go to COMPARE, which then hits.
- The cache issues no writes to memory except victim write-backs.
- `cache_stall` = (state != IDLE && !`cache_resp_valid`) || (state == IDLE && `cache_req_valid`).
- Requests that arrive outside IDLE are not sampled; the core holds them.
- `mem_resp_valid` is ignored in IDLE and COMPARE.

## Timing
- All outputs are registered or decoded from the registered state and request registers, with no input-to-output path except the IDLE term of `cache_stall`.
- Reset (`rstn`=0, asynchronous): state=IDLE, all valid and dirty bits=0, all outputs 0.
  - Line data and tag arrays are not reset.
- Hit latency: request sampled at edge E; `cache_resp_valid`=1 in the cycle after E (COMPARE). Back-to-back hits are accepted every 2 cycles.
- Clean miss: E, then COMPARE (1 cycle), then ALLOC (≥1 cycle, until `mem_resp_valid`), then COMPARE with response. Minimum 3 cycles after E.
- Dirty miss: adds WRBACK (≥1 cycle). Minimum 4 cycles after E.
- `mem_req_valid` rises on entry to WRBACK/ALLOC and falls the cycle after `mem_resp_valid` is sampled.
- Address, wen and data stay stable while `mem_req_valid`=1.
- Entering ALLOC directly from WRBACK keeps `mem_req_valid`=1 continuously, with the address and wen switching at that edge.
- The core deasserts or changes `cache_req_valid` in the cycle after `cache_resp_valid`. If it is still high in IDLE, it is a new request.
- Reset mid-miss drops `mem_req_valid` immediately and produces no response. The interrupted write-back is lost; this is acceptable because reset also invalidates the cache.

## Test plan
- Reset, then LW 0x0000_0010 with memory returning 0xDEAD_BEEF after 2 cycles -> `mem_req_valid`/wen=0/addr 0x10; `cache_resp_valid` with data 0xDEAD_BEEF; line 4 valid, clean.
- Repeat LW 0x10 -> hit, resp 0xDEAD_BEEF one cycle after acceptance, `mem_req_valid` stays 0.
- SW 0x10 data 0x1234_5678 -> hit, no memory traffic, line 4 dirty; then LW 0x10 -> 0x1234_5678.
- LW 0x0000_0110 (same index 4, different tag), memory returns 0xCAFE_0001 -> first a write request addr 0x10 data 0x1234_5678, then a read request addr 0x110; response 0xCAFE_0001; line 4 clean.
- SW miss 0x0000_0020 data 0xA5A5_A5A5 -> read request addr 0x20, then resp; later LW 0x20 hits with 0xA5A5_A5A5; memory latency 0 and 5 cycles both pass.
- Assert `rstn`=0 during ALLOC -> `mem_req_valid`=0 and `cache_stall`=0 immediately, no `cache_resp_valid`; the next LW 0x110 misses.
